// File: rtl/proc_control_if.sv
// rtl/proc_control_if.sv - instruction/bus-control signal bundle for proc_control
interface proc_control_if;
  // Instruction source side
  logic        Run;
  logic [15:0] DIN;

  // Bus mux select and sink load enables
  logic [9:0]  Control;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;

  // Instruction source / datapath side
  modport master (
    output Run,
    output DIN,
    input  Control,
    input  Rin,
    input  Ain,
    input  Gin,
    input  AddSub,
    input  Done
  );

  // Control unit side
  modport slave (
    input  Run,
    input  DIN,
    output Control,
    output Rin,
    output Ain,
    output Gin,
    output AddSub,
    output Done
  );
endinterface

// File: rtl/proc_control.sv
// rtl/proc_control.sv - T0..T3 sequencer driving bus-source select and sink load enables
module proc_control (
  input  logic          Clock,
  input  logic          Resetn,
  proc_control_if.slave bus
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [9:0] SEL_NONE = 10'b00_0000_0000;
  localparam logic [9:0] SEL_DIN  = 10'b00_0000_0001;
  localparam logic [9:0] SEL_G    = 10'b00_0000_0010;

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_ir;

  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [7:0] w_x_load;
  logic [9:0] w_x_sel;
  logic [9:0] w_y_sel;

  logic [9:0] w_control;
  logic [7:0] w_rin;
  logic       w_ain;
  logic       w_gin;
  logic       w_addsub;
  logic       w_done;

  // Only DIN[8:0] forms the instruction; the upper bits are the immediate's domain.
  logic       w_unused_din;
  assign w_unused_din = ^bus.DIN[15:9];

  // Register n sits on bus-select bit 9-n (R0 at bit 9, R7 at bit 2).
  function automatic logic [9:0] reg_sel(input logic [2:0] r);
    logic [3:0] w_pos;
    w_pos   = 4'd9 - {1'b0, r};
    reg_sel = 10'd1 << w_pos;
  endfunction

  assign w_op     = r_ir[8:6];
  assign w_x      = r_ir[5:3];
  assign w_y      = r_ir[2:0];
  assign w_x_load = 8'd1 << w_x;
  assign w_x_sel  = reg_sel(w_x);
  assign w_y_sel  = reg_sel(w_y);

  // State register and instruction capture; reset aborts any instruction in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= 9'd0;
    end else begin
      r_state <= w_next;
      if (r_state == T0 && bus.Run) begin
        r_ir <= bus.DIN[8:0];
      end
    end
  end

  // Next-state and output decode from state and IR; T0 never drives a source or sink.
  always_comb begin
    w_next    = r_state;
    w_control = SEL_NONE;
    w_rin     = 8'd0;
    w_ain     = 1'b0;
    w_gin     = 1'b0;
    w_addsub  = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      T0: begin
        if (bus.Run) begin
          w_next = T1;
        end
      end

      T1: begin
        case (w_op)
          OP_MV: begin
            w_control = w_y_sel;
            w_rin     = w_x_load;
            w_done    = 1'b1;
            w_next    = T0;
          end
          OP_MVI: begin
            w_control = SEL_DIN;
            w_rin     = w_x_load;
            w_done    = 1'b1;
            w_next    = T0;
          end
          OP_ADD, OP_SUB: begin
            w_control = w_x_sel;
            w_ain     = 1'b1;
            w_next    = T2;
          end
          default: begin
            // Reserved opcodes complete as a one-cycle nop.
            w_done = 1'b1;
            w_next = T0;
          end
        endcase
      end

      T2: begin
        // Only add/sub reach T2: second operand goes through the ALU into G.
        w_control = w_y_sel;
        w_gin     = 1'b1;
        w_addsub  = (w_op == OP_SUB);
        w_next    = T3;
      end

      T3: begin
        w_control = SEL_G;
        w_rin     = w_x_load;
        w_done    = 1'b1;
        w_next    = T0;
      end

      default: begin
        w_next = T0;
      end
    endcase
  end

  assign bus.Control = w_control;
  assign bus.Rin     = w_rin;
  assign bus.Ain     = w_ain;
  assign bus.Gin     = w_gin;
  assign bus.AddSub  = w_addsub;
  assign bus.Done    = w_done;

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - directed and random instruction sequences checked against an architectural model
module tb_proc_control;

  logic Clock;
  logic Resetn;

  proc_control_if bus ();

  proc_control dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;

  // Simple datapath driven by the DUT's control outputs.
  logic [15:0] dp_r [8];
  logic [15:0] dp_a;
  logic [15:0] dp_g;
  logic [15:0] dp_bus;

  // Architectural register state, updated from instruction semantics alone.
  logic [15:0] arch [8];

  always_comb begin
    dp_bus = 16'd0;
    if (bus.Control[0]) dp_bus = dp_bus | bus.DIN;
    if (bus.Control[1]) dp_bus = dp_bus | dp_g;
    for (int r = 0; r < 8; r++) begin
      if (bus.Control[9 - r]) dp_bus = dp_bus | dp_r[r];
    end
  end

  always @(posedge Clock) begin
    for (int r = 0; r < 8; r++) begin
      if (bus.Rin[r]) dp_r[r] <= dp_bus;
    end
    if (bus.Ain) dp_a <= dp_bus;
    if (bus.Gin) dp_g <= bus.AddSub ? (dp_a - dp_bus) : (dp_a + dp_bus);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [20:0] pack_outs();
    return {bus.Control, bus.Rin, bus.Ain, bus.Gin, bus.Done};
  endfunction

  function automatic logic [9:0] src_of(input int r);
    return 10'd1 << (9 - r);
  endfunction

  task automatic chk_idle(input string tag);
    chk(tag, {11'd0, pack_outs()}, 32'd0);
  endtask

  task automatic chk_regs(input string tag);
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("%s_r%0d", tag, r), {16'd0, dp_r[r]}, {16'd0, arch[r]});
    end
  endtask

  // Issue one instruction from T0 and check every timestep against the opcode's schedule.
  task automatic run_instr(input logic [8:0] ir, input logic [15:0] imm,
                           input logic [6:0] hi, input bit toggle_run);
    logic [2:0]  op;
    int          x;
    int          y;
    int          n;
    logic [20:0] exp_o  [3];
    logic        exp_as [3];

    op = ir[8:6];
    x  = int'(ir[5:3]);
    y  = int'(ir[2:0]);
    for (int i = 0; i < 3; i++) begin
      exp_o[i]  = 21'd0;
      exp_as[i] = 1'b0;
    end

    if (op == 3'd0) begin
      n = 1;
      exp_o[0] = {src_of(y), 8'd1 << x, 3'b001};
    end else if (op == 3'd1) begin
      n = 1;
      exp_o[0] = {10'h001, 8'd1 << x, 3'b001};
    end else if (op == 3'd2 || op == 3'd3) begin
      n = 3;
      exp_o[0]  = {src_of(x), 8'd0, 3'b100};
      exp_o[1]  = {src_of(y), 8'd0, 3'b010};
      exp_as[1] = (op == 3'd3);
      exp_o[2]  = {10'h002, 8'd1 << x, 3'b001};
    end else begin
      n = 1;
      exp_o[0] = {10'h000, 8'd0, 3'b001};
    end

    bus.Run = 1'b1;
    bus.DIN = {hi, ir};
    chk_idle($sformatf("t0_ir%03h", ir));
    tick();

    for (int s = 0; s < n; s++) begin
      bus.DIN = imm;
      bus.Run = toggle_run ? 1'($urandom) : 1'b1;
      chk($sformatf("ir%03h_t%0d", ir, s + 1), {11'd0, pack_outs()}, {11'd0, exp_o[s]});
      if (exp_o[s][1]) begin
        chk($sformatf("ir%03h_addsub", ir), {31'd0, bus.AddSub}, {31'd0, exp_as[s]});
      end
      tick();
    end

    case (op)
      3'd0: arch[x] = arch[y];
      3'd1: arch[x] = imm;
      3'd2: arch[x] = arch[x] + arch[y];
      3'd3: arch[x] = arch[x] - arch[y];
      default: ;
    endcase
    chk_regs($sformatf("ir%03h", ir));
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      dp_r[r] = 16'd0;
      arch[r] = 16'd0;
    end
    dp_a = 16'd0;
    dp_g = 16'd0;

    // Reset held with Run high and an mvi R1 on DIN: nothing may move.
    Resetn  = 1'b0;
    bus.Run = 1'b1;
    bus.DIN = 16'h0048;
    #1;
    chk_idle("rst_hold0");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rst_hold");
    end
    Resetn  = 1'b1;
    bus.Run = 1'b0;
    chk_idle("rst_release");
    tick();
    chk_idle("idle_after_rst");
    chk_regs("rst");

    // Directed instructions from the test plan.
    run_instr(9'h040, 16'h1234, 7'd0, 1'b0);
    chk("mvi_r0", {16'd0, dp_r[0]}, 32'h1234);
    run_instr(9'h050, 16'hBEEF, 7'd0, 1'b0);
    run_instr(9'h00A, 16'h0000, 7'd0, 1'b0);
    chk("mv_r1", {16'd0, dp_r[1]}, 32'hBEEF);
    run_instr(9'h040, 16'd5, 7'd0, 1'b0);
    run_instr(9'h048, 16'd7, 7'd0, 1'b0);
    run_instr(9'h081, 16'h0000, 7'd0, 1'b1);
    chk("add_r0", {16'd0, dp_r[0]}, 32'd12);
    run_instr(9'h058, 16'd9, 7'd0, 1'b0);
    run_instr(9'h0DB, 16'h0000, 7'd0, 1'b1);
    chk("sub_r3", {16'd0, dp_r[3]}, 32'd0);
    run_instr(9'h100, 16'hFFFF, 7'd0, 1'b0);

    // Idle cycles with Run low stay in T0.
    bus.Run = 1'b0;
    chk_idle("idle0");
    tick();
    chk_idle("idle1");

    // Reset in T2 of add R0,R1 aborts the add before G or R0 load.
    bus.Run = 1'b1;
    bus.DIN = 16'h0081;
    tick();
    bus.Run = 1'b0;
    chk("abort_t1", {11'd0, pack_outs()}, {11'd0, 10'h200, 8'd0, 3'b100});
    tick();
    chk("abort_t2", {11'd0, pack_outs()}, {11'd0, 10'h100, 8'd0, 3'b010});
    #2;
    Resetn = 1'b0;
    #1;
    chk_idle("abort_async");
    tick();
    chk_idle("abort_held");
    Resetn = 1'b1;
    chk_idle("abort_release");
    tick();
    chk_idle("abort_no_t3");
    chk_regs("abort");

    // Random instructions, Run wiggled in T1..T3, occasional idle gaps.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.Run = 1'b0;
        bus.DIN = 16'($urandom);
        chk_idle("rand_idle");
        tick();
      end
      run_instr(9'($urandom), 16'($urandom), 7'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
